// File: rtl/synaptic_update_engine.sv
// Synaptic core with its own row sequencer: sweeps one pre-neuron row
// of weight/gradient memory doing accumulate, apply or inference RMW.
module synaptic_update_engine #(
   parameter int INPUT_NEURON       = 784,
   parameter int OUTPUT_NEURON      = 256,
   parameter int POST_NEUR_PARALLEL = 4,
   parameter int WEIGHT_WIDTH       = 8,
   parameter int GRAD_WIDTH         = 8,
   parameter int PRE_CNT_WIDTH      = 8,
   parameter int POST_CNT_WIDTH     = 7,
   parameter int DELTA_SHIFT        = 0,
   parameter int LR_SHIFT           = 2,
   localparam int WORDS_PER_ROW     = OUTPUT_NEURON / POST_NEUR_PARALLEL,
   localparam int ADDR_WIDTH        = $clog2(INPUT_NEURON * WORDS_PER_ROW)
) (
   input  logic                                         CLK,
   input  logic                                         RST_N,
   input  logic                                         START,
   input  logic                                         ABORT,
   input  logic [1:0]                                   MODE,
   input  logic                                         IS_POS,
   input  logic [$clog2(INPUT_NEURON)-1:0]              PRE_ADDR,
   input  logic [PRE_CNT_WIDTH-1:0]                     PRE_S_CNT,
   input  logic [POST_CNT_WIDTH*POST_NEUR_PARALLEL-1:0] POST_S_CNT,
   output logic [$clog2(WORDS_PER_ROW)-1:0]             POST_WORD_ADDR,
   output logic                                         BUSY,
   output logic                                         DONE,
   output logic [WEIGHT_WIDTH*POST_NEUR_PARALLEL-1:0]   W_RDATA,
   output logic                                         W_RVALID
);

   localparam int PRE_W = $clog2(INPUT_NEURON);
   localparam int WA_W  = $clog2(WORDS_PER_ROW);
   localparam int DEPTH = INPUT_NEURON * WORDS_PER_ROW;
   localparam int WW    = WEIGHT_WIDTH * POST_NEUR_PARALLEL;
   localparam int GW    = GRAD_WIDTH * POST_NEUR_PARALLEL;
   localparam int PW    = PRE_CNT_WIDTH + POST_CNT_WIDTH;
   localparam int SW    = (WEIGHT_WIDTH > GRAD_WIDTH ?
                           WEIGHT_WIDTH : GRAD_WIDTH) + 2;

   localparam logic [GRAD_WIDTH-1:0] D_MAX =
      {1'b0, {(GRAD_WIDTH-1){1'b1}}};
   localparam logic signed [GRAD_WIDTH+1:0] ACC_MAX =
      {3'b000, {(GRAD_WIDTH-1){1'b1}}};
   localparam logic signed [GRAD_WIDTH+1:0] ACC_MIN = ~ACC_MAX;
   localparam logic [WEIGHT_WIDTH-1:0] W_MAX =
      {1'b0, {(WEIGHT_WIDTH-1){1'b1}}};
   localparam logic signed [SW-1:0] S_MAX =
      {{(SW-WEIGHT_WIDTH+1){1'b0}}, {(WEIGHT_WIDTH-1){1'b1}}};
   localparam logic signed [SW-1:0] S_MIN = ~S_MAX;

   typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;

   state_t                   state;
   logic [PRE_W-1:0]         row_q;
   logic [PRE_CNT_WIDTH-1:0] pre_q;
   logic [1:0]               mode_q;
   logic                     is_pos_q;

   logic [WW-1:0]            w_mem [DEPTH];
   logic [GW-1:0]            g_mem [DEPTH];
   logic [WW-1:0]            w_q;
   logic [WW-1:0]            w_new;
   logic [GW-1:0]            g_q;
   logic [GW-1:0]            g_new;
   logic [ADDR_WIDTH-1:0]    addr;
   logic                     mem_re;
   logic                     mem_we;
   logic                     last;

   // Modes 2 and 3 both have bit 1 set: read-only sweeps.
   assign mem_re = (state == READ);
   assign mem_we = (state == WRITE) && !mode_q[1] && !ABORT;
   assign last   = (POST_WORD_ADDR == WA_W'(WORDS_PER_ROW - 1));
   assign addr   = ADDR_WIDTH'(row_q) * ADDR_WIDTH'(WORDS_PER_ROW)
                 + ADDR_WIDTH'(POST_WORD_ADDR);

   always_ff @(posedge CLK) begin
      if (mem_we) begin
         w_mem[addr] <= w_new;
         g_mem[addr] <= g_new;
      end
      if (mem_re) begin
         w_q <= w_mem[addr];
         g_q <= g_mem[addr];
      end
   end

   assign W_RDATA = W_RVALID ? w_q : '0;

   for (genvar i = 0; i < POST_NEUR_PARALLEL; i++) begin : g_lane
      logic signed [WEIGHT_WIDTH-1:0] w_old;
      logic signed [WEIGHT_WIDTH-1:0] w_sat;
      logic signed [GRAD_WIDTH-1:0]   g_old;
      logic signed [GRAD_WIDTH-1:0]   g_sat;
      logic signed [GRAD_WIDTH-1:0]   step;
      logic [POST_CNT_WIDTH-1:0]      post;
      logic [PW-1:0]                  prod;
      logic [GRAD_WIDTH-1:0]          d;
      logic signed [GRAD_WIDTH+1:0]   acc;
      logic signed [SW-1:0]           sum;

      assign w_old = w_q[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      assign g_old = g_q[i*GRAD_WIDTH +: GRAD_WIDTH];
      assign post  = POST_S_CNT[i*POST_CNT_WIDTH +: POST_CNT_WIDTH];

      assign prod = (PW'(pre_q) * PW'(post)) >> DELTA_SHIFT;
      assign d    = (prod > PW'(D_MAX)) ? D_MAX
                                        : prod[GRAD_WIDTH-1:0];
      assign acc  = is_pos_q
                  ? {{2{g_old[GRAD_WIDTH-1]}}, g_old} + {2'b00, d}
                  : {{2{g_old[GRAD_WIDTH-1]}}, g_old} - {2'b00, d};
      assign g_sat = (acc > ACC_MAX) ? D_MAX
                   : (acc < ACC_MIN) ? ~D_MAX
                   : acc[GRAD_WIDTH-1:0];

      assign step  = g_old >>> LR_SHIFT;
      assign sum   = {{(SW-WEIGHT_WIDTH){w_old[WEIGHT_WIDTH-1]}}, w_old}
                   + {{(SW-GRAD_WIDTH){step[GRAD_WIDTH-1]}}, step};
      assign w_sat = (sum > S_MAX) ? W_MAX
                   : (sum < S_MIN) ? ~W_MAX
                   : sum[WEIGHT_WIDTH-1:0];

      assign w_new[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] =
         mode_q[0] ? w_sat : w_old;
      assign g_new[i*GRAD_WIDTH +: GRAD_WIDTH] =
         mode_q[0] ? '0 : g_sat;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state          <= IDLE;
         BUSY           <= 1'b0;
         DONE           <= 1'b0;
         W_RVALID       <= 1'b0;
         POST_WORD_ADDR <= '0;
         row_q          <= '0;
         pre_q          <= '0;
         mode_q         <= '0;
         is_pos_q       <= 1'b0;
      end else begin
         DONE     <= 1'b0;
         W_RVALID <= 1'b0;
         unique case (state)
            IDLE: begin
               if (START && !ABORT) begin
                  row_q          <= PRE_ADDR;
                  pre_q          <= PRE_S_CNT;
                  mode_q         <= MODE;
                  is_pos_q       <= IS_POS;
                  POST_WORD_ADDR <= '0;
                  BUSY           <= 1'b1;
                  state          <= READ;
               end
            end
            READ: begin
               if (ABORT) begin
                  BUSY  <= 1'b0;
                  state <= IDLE;
               end else begin
                  W_RVALID <= 1'b1;
                  state    <= WRITE;
               end
            end
            WRITE: begin
               if (ABORT) begin
                  BUSY  <= 1'b0;
                  state <= IDLE;
               end else if (last) begin
                  BUSY  <= 1'b0;
                  DONE  <= 1'b1;
                  state <= FIN;
               end else begin
                  POST_WORD_ADDR <= POST_WORD_ADDR + 1'b1;
                  state          <= READ;
               end
            end
            FIN: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_synaptic_update_engine.sv
// Scoreboard bench for synaptic_update_engine: a behavioural memory
// model predicts every W_RDATA word and sweep latency.
module tb_synaptic_update_engine;

   localparam int NR = 4;
   localparam int NW = 2;
   localparam int NL = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic        is_pos = 1'b0;
   logic [1:0]  pre_addr = 2'd0;
   logic [7:0]  pre_s_cnt = 8'd0;
   logic [27:0] post_s_cnt;
   logic [0:0]  post_word_addr;
   logic        busy;
   logic        done;
   logic [31:0] w_rdata;
   logic        w_rvalid;

   int          mw [NR][NW][NL];
   int          mg [NR][NW][NL];
   int          post_tab [NW][NL];
   int          tw [NW][NL];
   int          tg [NW][NL];
   logic [32:0] exp_q [$];
   bit          track = 1'b0;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   synaptic_update_engine #(
      .INPUT_NEURON      (NR),
      .OUTPUT_NEURON     (NW * NL),
      .POST_NEUR_PARALLEL(NL),
      .WEIGHT_WIDTH      (8),
      .GRAD_WIDTH        (8),
      .PRE_CNT_WIDTH     (8),
      .POST_CNT_WIDTH    (7),
      .DELTA_SHIFT       (0),
      .LR_SHIFT          (2)
   ) dut (
      .CLK           (clk),
      .RST_N         (rst_n),
      .START         (start),
      .ABORT         (abort),
      .MODE          (mode),
      .IS_POS        (is_pos),
      .PRE_ADDR      (pre_addr),
      .PRE_S_CNT     (pre_s_cnt),
      .POST_S_CNT    (post_s_cnt),
      .POST_WORD_ADDR(post_word_addr),
      .BUSY          (busy),
      .DONE          (done),
      .W_RDATA       (w_rdata),
      .W_RVALID      (w_rvalid)
   );

   always_comb begin
      post_s_cnt = '0;
      for (int i = 0; i < NL; i++)
         post_s_cnt[i*7 +: 7] = 7'(post_tab[post_word_addr][i]);
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int clamp(input int v);
      return (v > 127) ? 127 : ((v < -128) ? -128 : v);
   endfunction

   function automatic logic [32:0] pack(input int row, input int w);
      logic [32:0] r;
      int          v;
      r = '0;
      r[32] = w[0];
      for (int i = 0; i < NL; i++) begin
         v = mw[row][w][i];
         r[i*8 +: 8] = v[7:0];
      end
      return r;
   endfunction

   // Model of one sweep over words [0, upto).
   task automatic model(input int md, input bit pos, input int row,
                        input int pre, input int upto);
      int p;
      for (int w = 0; w < upto; w++)
         for (int i = 0; i < NL; i++) begin
            if (md == 0) begin
               p = pre * post_tab[w][i];
               if (p > 127) p = 127;
               mg[row][w][i] = clamp(mg[row][w][i] + (pos ? p : -p));
            end else if (md == 1) begin
               mw[row][w][i] = clamp(mw[row][w][i] + (mg[row][w][i] >>> 2));
               mg[row][w][i] = 0;
            end
         end
   endtask

   always @(negedge clk) begin
      if (rst_n && w_rvalid && track) begin
         if (exp_q.size() == 0) check("rd_extra", w_rvalid, 1'b0);
         else check("rd", {post_word_addr, w_rdata}, exp_q.pop_front());
      end
   end

   task automatic run(input logic [1:0] md, input bit pos, input int row,
                      input int pre, input bit poke);
      int lat;
      int hits;
      if (track)
         for (int w = 0; w < NW; w++) exp_q.push_back(pack(row, w));
      @(negedge clk);
      start = 1'b1;
      mode = md;
      is_pos = pos;
      pre_addr = 2'(row);
      pre_s_cnt = 8'(pre);
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (!done && lat < 20) begin
         start = poke && (lat == 2);
         if (start) begin
            mode = 2'd0;
            pre_s_cnt = 8'd255;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      if (track) check("lat", lat, 5);
      model(md, pos, row, pre, NW);
      if (poke) begin
         hits = 0;
         repeat (6) begin
            @(negedge clk);
            if (busy) hits++;
         end
         check("poke_idle", hits, 0);
      end
   endtask

   task automatic fill_post(input int v);
      for (int w = 0; w < NW; w++)
         for (int i = 0; i < NL; i++) post_tab[w][i] = v;
   endtask

   task automatic dump(input int row);
      run(2'd2, 1'b0, row, 0, 1'b0);
   endtask

   // Any start state: clear grads, then drive every weight to -128.
   task automatic floor_row(input int row);
      bit keep;
      keep = track;
      track = 1'b0;
      fill_post(127);
      run(2'd1, 1'b0, row, 1, 1'b0);
      repeat (8) begin
         run(2'd0, 1'b0, row, 1, 1'b0);
         run(2'd1, 1'b0, row, 1, 1'b0);
      end
      for (int w = 0; w < NW; w++)
         for (int i = 0; i < NL; i++) begin
            mw[row][w][i] = -128;
            mg[row][w][i] = 0;
         end
      track = keep;
   endtask

   task automatic set_weights(input int row);
      bit more;
      int s;
      more = 1'b1;
      while (more) begin
         more = 1'b0;
         for (int w = 0; w < NW; w++)
            for (int i = 0; i < NL; i++) begin
               s = tw[w][i] - mw[row][w][i];
               if (s > 31) s = 31;
               if (s < 0) s = 0;
               if (s > 0) more = 1'b1;
               post_tab[w][i] = 4 * s;
            end
         if (more) begin
            run(2'd0, 1'b1, row, 1, 1'b0);
            run(2'd1, 1'b0, row, 1, 1'b0);
         end
      end
   endtask

   task automatic set_grads(input int row);
      for (int w = 0; w < NW; w++)
         for (int i = 0; i < NL; i++)
            post_tab[w][i] = (tg[w][i] > 0) ? tg[w][i] : 0;
      run(2'd0, 1'b1, row, 1, 1'b0);
      for (int w = 0; w < NW; w++)
         for (int i = 0; i < NL; i++)
            post_tab[w][i] = (tg[w][i] < 0) ? -tg[w][i] : 0;
      run(2'd0, 1'b0, row, 1, 1'b0);
   endtask

   task automatic set_word(input int w, input int a, input int b,
                           input int c, input int e);
      post_tab[w][0] = a;
      post_tab[w][1] = b;
      post_tab[w][2] = c;
      post_tab[w][3] = e;
   endtask

   task automatic abort_apply(input int row);
      int n;
      int dn;
      exp_q.push_back(pack(row, 0));
      exp_q.push_back(pack(row, 1));
      @(negedge clk);
      start = 1'b1;
      mode = 2'd1;
      pre_addr = 2'(row);
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!(w_rvalid && post_word_addr == 1'b1) && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("abort_reach", n < 20, 1'b1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", busy, 1'b0);
      dn = 0;
      repeat (8) begin
         if (done) dn++;
         @(negedge clk);
      end
      check("abort_done", dn, 0);
      model(1, 1'b0, row, 1, 1);
   endtask

   initial begin
      fill_post(0);
      #2 rst_n = 1'b0;
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_rvalid", w_rvalid, 1'b0);
      check("rst_rdata", w_rdata, 32'd0);
      check("rst_waddr", post_word_addr, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Accumulate: grads {12,0,4,8}, weights untouched.
      floor_row(0);
      track = 1'b1;
      set_word(0, 3, 0, 1, 2);
      set_word(1, 3, 0, 1, 2);
      run(2'd0, 1'b1, 0, 4, 1'b0);
      dump(0);
      run(2'd1, 1'b0, 0, 1, 1'b0);
      dump(0);

      // Gradient saturation and delta clamp.
      floor_row(1);
      fill_post(0);
      for (int w = 0; w < NW; w++)
         for (int i = 0; i < NL; i++) begin
            tw[w][i] = 0;
            tg[w][i] = 0;
         end
      set_weights(1);
      tg[0][0] = 120;
      tg[0][1] = -120;
      tg[1][2] = -120;
      set_grads(1);
      fill_post(0);
      set_word(0, 3, 0, 0, 0);
      run(2'd0, 1'b1, 1, 4, 1'b0);
      set_word(0, 0, 3, 0, 0);
      run(2'd0, 1'b0, 1, 4, 1'b0);
      fill_post(0);
      set_word(1, 0, 0, 127, 1);
      run(2'd0, 1'b1, 1, 255, 1'b0);
      run(2'd1, 1'b0, 1, 1, 1'b0);
      dump(1);

      // Apply with weight saturation.
      floor_row(2);
      for (int w = 0; w < NW; w++)
         for (int i = 0; i < NL; i++) begin
            tw[w][i] = 0;
            tg[w][i] = 0;
         end
      tw[0][0] = 10;
      tw[0][1] = -128;
      tw[0][2] = 126;
      tw[0][3] = 5;
      tw[1][0] = 126;
      set_weights(2);
      tg[0][0] = 12;
      tg[0][1] = -8;
      tg[0][3] = 3;
      tg[1][0] = 12;
      set_grads(2);
      run(2'd1, 1'b0, 2, 1, 1'b0);
      dump(2);
      dump(2);
      run(2'd1, 1'b0, 2, 1, 1'b0);
      dump(2);
      run(2'd3, 1'b1, 2, 255, 1'b1);
      dump(2);

      // Abort in the WRITE of word 1.
      floor_row(3);
      for (int w = 0; w < NW; w++)
         for (int i = 0; i < NL; i++) begin
            tw[w][i] = 0;
            tg[w][i] = 40;
         end
      set_weights(3);
      set_grads(3);
      abort_apply(3);
      dump(3);
      run(2'd1, 1'b0, 3, 1, 1'b0);
      dump(3);

      // Reset during READ.
      @(negedge clk);
      start = 1'b1;
      mode = 2'd1;
      pre_addr = 2'd2;
      @(negedge clk);
      start = 1'b0;
      check("pre_rst_busy", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_waddr", post_word_addr, 1'b0);
      check("mid_rst_rdata", w_rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dump(2);

      // START with ABORT in IDLE is dropped.
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      mode = 2'd1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("start_abort", busy, 1'b0);
      dump(2);

      check("q_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
